// File: rtl/i2c_pkg.sv
// Shared command codes, FSM states and bus constants for the I2C write scheduler.
package i2c_pkg;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_STOP  = 2'b10;

    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START_ISS,
        ST_START_WT,
        ST_ADDR_ISS,
        ST_ADDR_WT,
        ST_DATA_ISS,
        ST_DATA_WT,
        ST_STOP_ISS,
        ST_STOP_WT,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Combinational round-robin pick: first set req bit scanning upward from ptr+1, wrapping.
module i2c_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    // Scan from farthest to nearest so the nearest requester after ptr wins last.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        cand = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(ptr) + k) % N_REQ);
            if (req[cand]) begin
                idx = cand;
                gnt = N_REQ'(1) << cand;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/i2c_write_scheduler.sv
// Shares one byte-level I2C master among N_REQ single-byte register writers,
// sequencing START / address / data / STOP with bounded retry on NACK.
module i2c_write_scheduler #(
    parameter int N_REQ     = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N_REQ-1:0]   req,
    input  logic [7*N_REQ-1:0] req_addr,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic [N_REQ-1:0]   err,
    output logic               busy,
    output logic               eng_cmd_valid,
    output logic [1:0]         eng_cmd,
    output logic [7:0]         eng_cmd_byte,
    input  logic               eng_cmd_ready,
    input  logic               eng_rsp_valid,
    input  logic               eng_rsp_nack
);

    import i2c_pkg::*;

    localparam int IDX_W = $clog2(N_REQ);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, arb_idx;
    logic [N_REQ-1:0] arb_gnt;
    logic             arb_any;
    logic [6:0]       addr_q;
    logic [7:0]       data_q;
    logic [2:0]       retry_cnt;
    logic             nack_flag;
    logic             retry_ok;

    logic [6:0] addr_arr [N_REQ];
    logic [7:0] data_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign addr_arr[i] = req_addr[7*i +: 7];
        assign data_arr[i] = req_data[8*i +: 8];
    end

    i2c_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign retry_ok = nack_flag && (retry_cnt < 3'(MAX_RETRY));
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_FINISH && !nack_flag)            ? gnt : '0;
    assign err      = (state == ST_FINISH && nack_flag && !retry_ok) ? gnt : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        eng_cmd_valid = 1'b0;
        eng_cmd       = CMD_START;
        eng_cmd_byte  = 8'h00;
        case (state)
            ST_IDLE:      if (arb_any) state_nxt = ST_START_ISS;
            ST_START_ISS: begin
                eng_cmd_valid = 1'b1;
                if (eng_cmd_ready) state_nxt = ST_START_WT;
            end
            ST_START_WT:  if (eng_rsp_valid) state_nxt = ST_ADDR_ISS;
            ST_ADDR_ISS: begin
                eng_cmd_valid = 1'b1;
                eng_cmd       = CMD_WRITE;
                eng_cmd_byte  = {addr_q, RW_WRITE};
                if (eng_cmd_ready) state_nxt = ST_ADDR_WT;
            end
            ST_ADDR_WT:
                if (eng_rsp_valid) state_nxt = eng_rsp_nack ? ST_STOP_ISS : ST_DATA_ISS;
            ST_DATA_ISS: begin
                eng_cmd_valid = 1'b1;
                eng_cmd       = CMD_WRITE;
                eng_cmd_byte  = data_q;
                if (eng_cmd_ready) state_nxt = ST_DATA_WT;
            end
            ST_DATA_WT:   if (eng_rsp_valid) state_nxt = ST_STOP_ISS;
            ST_STOP_ISS: begin
                eng_cmd_valid = 1'b1;
                eng_cmd       = CMD_STOP;
                if (eng_cmd_ready) state_nxt = ST_STOP_WT;
            end
            ST_STOP_WT:   if (eng_rsp_valid) state_nxt = ST_FINISH;
            // Grant is never reissued here; a retry reuses the latched operands.
            ST_FINISH:    state_nxt = retry_ok ? ST_START_ISS : ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            gnt       <= '0;
            ptr       <= IDX_W'(N_REQ - 1);
            addr_q    <= '0;
            data_q    <= '0;
            retry_cnt <= '0;
            nack_flag <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (arb_any) begin
                    gnt    <= arb_gnt;
                    ptr    <= arb_idx;
                    addr_q <= addr_arr[arb_idx];
                    data_q <= data_arr[arb_idx];
                end
                ST_ADDR_WT, ST_DATA_WT:
                    if (eng_rsp_valid && eng_rsp_nack) nack_flag <= 1'b1;
                ST_FINISH: begin
                    nack_flag <= 1'b0;
                    if (retry_ok) begin
                        retry_cnt <= retry_cnt + 3'd1;
                    end else begin
                        gnt       <= '0;
                        retry_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_write_scheduler.sv
// Randomized bench: behavioural engine + transaction-level model of arbitration and retry.
module tb_i2c_write_scheduler;

    localparam int N  = 4;
    localparam int MR = 2;

    logic         CLK = 1'b0;
    logic         RST;
    logic [N-1:0] req;
    logic [7*N-1:0] req_addr;
    logic [8*N-1:0] req_data;
    logic [N-1:0] gnt, done, err;
    logic         busy, eng_cmd_valid;
    logic [1:0]   eng_cmd;
    logic [7:0]   eng_cmd_byte;
    logic         eng_cmd_ready, eng_rsp_valid, eng_rsp_nack;

    i2c_write_scheduler #(.N_REQ(N), .MAX_RETRY(MR)) dut (
        .CLK(CLK), .RST(RST), .req(req), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .done(done), .err(err), .busy(busy),
        .eng_cmd_valid(eng_cmd_valid), .eng_cmd(eng_cmd), .eng_cmd_byte(eng_cmd_byte),
        .eng_cmd_ready(eng_cmd_ready), .eng_rsp_valid(eng_rsp_valid), .eng_rsp_nack(eng_rsp_nack)
    );

    always #5 CLK = ~CLK;

    int n_run = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester and model state. Outcome codes: 0 ACK, 1 address NACK, 2 data NACK.
    int         rem [N];
    logic [6:0] a [N];
    logic [7:0] d [N];
    int         plan[$], out_q[$];
    logic [9:0] exp_cmd[$], obs_cmd[$];
    int         exp_gnt[$], obs_gnt[$], exp_res[$], obs_res[$];
    int         model_ptr;

    // Engine state
    int         pend, wcnt, cur_o, bp_left, bp_seen;
    logic [1:0] pcmd;
    logic       prev_stall, prev_busy;
    logic [9:0] prev_cb;
    logic [N-1:0] prev_gnt;

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Transaction-level model: serve pending requesters round-robin, each up to MR+1 attempts.
    task automatic build_expect();
        int r [N];
        int last, j, o, x;
        r    = rem;
        last = model_ptr;
        while (1) begin
            j = -1;
            for (int k = 1; k <= N; k++)
                if (j < 0 && r[(last + k) % N] > 0) j = (last + k) % N;
            if (j < 0) break;
            exp_gnt.push_back(j);
            for (int att = 0; att <= MR; att++) begin
                if (plan.size() > 0) o = plan.pop_front();
                else begin
                    x = int'($urandom % 10);
                    o = (x < 6) ? 0 : (x < 8) ? 1 : 2;
                end
                out_q.push_back(o);
                exp_cmd.push_back(10'h000);
                exp_cmd.push_back({2'b01, a[j], 1'b0});
                if (o != 1) exp_cmd.push_back({2'b01, d[j]});
                exp_cmd.push_back({2'b10, 8'h00});
                if (o == 0) begin exp_res.push_back(j * 2); break; end
                if (att == MR) exp_res.push_back(j * 2 + 1);
            end
            r[j]--;
            last = j;
        end
        model_ptr = last;
    endtask

    // Monitor, requester bookkeeping and engine behaviour, all at the falling edge.
    initial forever @(negedge CLK) begin
        if (RST) begin
            pend = 0; wcnt = 0; pcmd = 2'b10; out_q.delete();
            eng_cmd_ready = 1'b0; eng_rsp_valid = 1'b0; eng_rsp_nack = 1'b0;
            prev_stall = 1'b0; prev_gnt = '0; prev_busy = 1'b0;
        end else begin
            chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
            chk("done_err_onehot0", 32'($onehot0(done | err)), 1);
            chk("busy_vs_gnt", 32'(busy), 32'(|gnt));
            if (prev_stall) begin
                chk("hold_valid", 32'(eng_cmd_valid), 1);
                chk("hold_cmd_byte", 32'({eng_cmd, eng_cmd_byte}), 32'(prev_cb));
            end
            if (gnt != '0 && prev_gnt == '0) begin
                obs_gnt.push_back(oh2i(gnt));
                chk("idle_gap", 32'(prev_busy), 0);
                chk("start_on_grant", 32'({eng_cmd_valid, eng_cmd}), 32'(3'b100));
            end
            for (int i = 0; i < N; i++) begin
                if (done[i]) obs_res.push_back(i * 2);
                if (err[i])  obs_res.push_back(i * 2 + 1);
                if (done[i] || err[i]) begin
                    rem[i]--;
                    if (rem[i] <= 0) req[i] = 1'b0;
                end
            end
            prev_gnt  = gnt;
            prev_busy = busy;

            eng_rsp_valid = 1'b0;
            eng_rsp_nack  = 1'($urandom);
            eng_cmd_ready = 1'b0;
            prev_stall    = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    eng_rsp_valid = 1'b1;
                    if (pcmd == 2'b01)
                        eng_rsp_nack = (wcnt == 1 && cur_o == 1) || (wcnt == 2 && cur_o == 2);
                end
            end else if (eng_cmd_valid) begin
                prev_cb = {eng_cmd, eng_cmd_byte};
                if (bp_left > 0 && pcmd == 2'b00) begin
                    chk("bp_cmd", 32'(eng_cmd), 32'(2'b01));
                    chk("bp_byte", 32'(eng_cmd_byte), 32'({a[oh2i(gnt)], 1'b0}));
                    bp_left--; bp_seen++;
                    prev_stall = 1'b1;
                end else if ($urandom % 3 == 0) begin
                    prev_stall = 1'b1;
                end else begin
                    eng_cmd_ready = 1'b1;
                    obs_cmd.push_back({eng_cmd, eng_cmd_byte});
                    pcmd = eng_cmd;
                    pend = int'($urandom_range(1, 3));
                    if (eng_cmd == 2'b00) begin
                        wcnt  = 0;
                        cur_o = (out_q.size() > 0) ? out_q.pop_front() : 0;
                    end else if (eng_cmd == 2'b01) begin
                        wcnt++;
                    end
                end
            end
        end
    end

    task automatic clear_q();
        exp_cmd.delete(); obs_cmd.delete(); exp_gnt.delete(); obs_gnt.delete();
        exp_res.delete(); obs_res.delete(); out_q.delete();
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_addr[7*i +: 7] = a[i];
            req_data[8*i +: 8] = d[i];
            req[i] = (rem[i] > 0);
        end
    endtask

    task automatic run_scn(input string nm);
        int t, pending;
        clear_q();
        build_expect();
        @(negedge CLK); #1;
        drive_reqs();
        @(posedge CLK); #1;
        chk($sformatf("%s lat_gnt", nm), 32'(gnt), 32'(N'(1) << exp_gnt[0]));
        chk($sformatf("%s lat_start", nm), 32'({eng_cmd_valid, eng_cmd}), 32'(3'b100));
        for (t = 0; t < 20000; t++) begin
            @(negedge CLK); #1;
            pending = 0;
            for (int i = 0; i < N; i++) if (rem[i] > 0) pending = 1;
            if (!busy && pending == 0) break;
        end
        chk($sformatf("%s finished", nm), 32'(t < 20000), 1);
        chk($sformatf("%s n_cmd", nm), obs_cmd.size(), exp_cmd.size());
        for (int i = 0; i < exp_cmd.size() && i < obs_cmd.size(); i++)
            chk($sformatf("%s cmd%0d", nm, i), 32'(obs_cmd[i]), 32'(exp_cmd[i]));
        chk($sformatf("%s n_gnt", nm), obs_gnt.size(), exp_gnt.size());
        for (int i = 0; i < exp_gnt.size() && i < obs_gnt.size(); i++)
            chk($sformatf("%s gnt%0d", nm, i), obs_gnt[i], exp_gnt[i]);
        chk($sformatf("%s n_res", nm), obs_res.size(), exp_res.size());
        for (int i = 0; i < exp_res.size() && i < obs_res.size(); i++)
            chk($sformatf("%s res%0d", nm, i), obs_res[i], exp_res[i]);
        chk($sformatf("%s idle_after", nm), 32'(busy), 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        req = '0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        @(negedge CLK); @(negedge CLK); #1;
        RST = 1'b0;
        model_ptr = N - 1;
    endtask

    task automatic set_rem(input int r0, input int r1, input int r2, input int r3);
        rem[0] = r0; rem[1] = r1; rem[2] = r2; rem[3] = r3;
    endtask

    task automatic chk_order(input string nm, input int n, input int e0, input int e1,
                             input int e2, input int e3, input int e4, input int e5);
        int e [6];
        e = '{e0, e1, e2, e3, e4, e5};
        for (int i = 0; i < n; i++)
            chk($sformatf("%s order%0d", nm, i), (obs_gnt.size() > i) ? obs_gnt[i] : -1, e[i]);
    endtask

    initial begin
        int t, any;
        RST = 1'b0; req = '0; req_addr = '0; req_data = '0;
        eng_cmd_ready = 1'b0; eng_rsp_valid = 1'b0; eng_rsp_nack = 1'b0;
        bp_left = 0; bp_seen = 0; model_ptr = N - 1;
        for (int i = 0; i < N; i++) begin rem[i] = 0; a[i] = 7'h50; d[i] = 8'hA5; end
        #1 RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst gnt", 32'(gnt), 0);
        chk("rst done", 32'(done), 0);
        chk("rst err", 32'(err), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst valid", 32'(eng_cmd_valid), 0);
        chk("rst cmd", 32'(eng_cmd), 0);
        chk("rst byte", 32'(eng_cmd_byte), 0);
        #1 RST = 1'b0;

        set_rem(1, 0, 0, 0); plan = '{0};
        run_scn("single");

        do_reset();
        set_rem(2, 2, 1, 1); plan = '{0, 0, 0, 0, 0, 0};
        run_scn("fair1111");
        chk_order("fair1111", 6, 0, 1, 2, 3, 0, 1);

        do_reset();
        set_rem(2, 0, 1, 0); plan = '{0, 0, 0};
        run_scn("fair0101");
        chk_order("fair0101", 3, 0, 2, 0, 0, 0, 0);

        do_reset();
        set_rem(0, 0, 1, 0); plan = '{1, 1, 1};
        run_scn("addr_nack");
        chk("addr_nack err2", (obs_res.size() == 1) ? obs_res[0] : -1, 5);

        do_reset();
        set_rem(1, 0, 0, 0); plan = '{2, 0};
        run_scn("data_nack_once");

        do_reset();
        set_rem(0, 1, 0, 0); plan = '{0};
        bp_left = 5; bp_seen = 0;
        run_scn("backpressure");
        chk("bp cycles", bp_seen, 5);

        // Random traffic with the arbiter pointer carried over between rounds
        for (int rnd = 0; rnd < 6; rnd++) begin
            any = 0;
            for (int i = 0; i < N; i++) begin
                rem[i] = int'($urandom_range(0, 2));
                a[i]   = 7'($urandom);
                d[i]   = 8'($urandom);
                if (rem[i] > 0) any = 1;
            end
            if (any == 0) rem[rnd % N] = 1;
            bp_left = int'($urandom_range(0, 2));
            run_scn($sformatf("rand%0d", rnd));
        end

        // Reset during the retry's data wait, then a fresh requester with a full retry budget
        do_reset();
        a[0] = 7'h50; d[0] = 8'hA5;
        set_rem(1, 0, 0, 0); plan = '{2, 0};
        clear_q();
        build_expect();
        @(negedge CLK); #1;
        drive_reqs();
        for (t = 0; t < 2000 && obs_cmd.size() < 7; t++) begin
            @(negedge CLK); #1;
        end
        chk("rst_mid reached", 32'(t < 2000), 1);
        @(posedge CLK); #2;
        RST = 1'b1;
        #1;
        chk("rst_mid gnt", 32'(gnt), 0);
        chk("rst_mid done", 32'(done), 0);
        chk("rst_mid err", 32'(err), 0);
        chk("rst_mid busy", 32'(busy), 0);
        chk("rst_mid valid", 32'(eng_cmd_valid), 0);
        chk("rst_mid cmd", 32'(eng_cmd), 0);
        chk("rst_mid byte", 32'(eng_cmd_byte), 0);
        req = '0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        @(negedge CLK); @(negedge CLK); #1;
        RST = 1'b0;
        model_ptr = N - 1;
        a[1] = 7'h2C; d[1] = 8'h3D;
        set_rem(0, 1, 0, 0); plan = '{1, 1, 0};
        run_scn("rst_recover");
        chk("rst_recover done1", (obs_res.size() == 1) ? obs_res[0] : -1, 2);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, tests run %0d", n_run);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2c_write_scheduler.md
Name: i2c_write_scheduler

Overview:
- Shares one I2C byte-level master engine among N_REQ requesters, each requesting a single-byte register write (7-bit slave address + 8-bit data).
- Round-robin arbitration grants one requester at a time.
- Sequences the engine through START, address byte, data byte and STOP, with bounded retry on NACK.
- Sits between on-chip clients and the bus engine, which drives the SDA/SCL pins.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_RETRY, 2, extra attempts after a NACK before reporting an error (0..7).

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- req  in  N_REQ  per-requester request level.
- req_addr  in  7*N_REQ  slave address; slice i = bits [7i+6:7i].
- req_data  in  8*N_REQ  write data; slice i = bits [8i+7:8i].
- gnt  out  N_REQ  one-hot grant, held for the whole transaction.
- done  out  N_REQ  one-cycle pulse on successful completion.
- err  out  N_REQ  one-cycle pulse when retries are exhausted.
- busy  out  1  high whenever state is not IDLE.
- eng_cmd_valid  out  1  command valid to the engine.
- eng_cmd  out  2  command code: 00 START, 01 WRITE, 10 STOP.
- eng_cmd_byte  out  8  byte for WRITE; 0 otherwise.
- eng_cmd_ready  in  1  engine accepts the command this cycle.
- eng_rsp_valid  in  1  engine finished the last command (one-cycle pulse).
- eng_rsp_nack  in  1  qualified by eng_rsp_valid on WRITE; SDA sampled high in the ACK slot.

Behaviour:
- Reset values:
  - gnt, done, err, busy, eng_cmd_valid, eng_cmd, eng_cmd_byte all 0.
  - state IDLE, retry_cnt 0, rr pointer = N_REQ-1 so index 0 has first priority.
- Reset asserted mid-transaction aborts immediately; no STOP is issued. The engine shares RST and resets itself.
- Arbitration:
  - Evaluated in IDLE only.
  - Winner is the first set req bit scanning upward, wrapping, from pointer+1.
  - Arbitration latches req_addr/req_data of the winner, sets gnt and updates the pointer to the winner.
- Latency: req rises in IDLE at edge k, so gnt=1 and eng_cmd_valid=1 with START from edge k+1.
- Command handshake:
  - eng_cmd_valid is held with eng_cmd and eng_cmd_byte stable until the cycle eng_cmd_ready=1.
  - eng_cmd_valid drops on the following edge.
  - Only one command is outstanding at a time.
- States (each X_ISS issues a command, each X_WT waits for eng_rsp_valid):
  - IDLE -> START_ISS when any req is set.
  - START_ISS -> START_WT -> ADDR_ISS.
  - ADDR_ISS (byte = {addr, 1'b0}; R/W=0, write) -> ADDR_WT.
  - ADDR_WT: ACK -> DATA_ISS; NACK -> set nack_flag, go to STOP_ISS.
  - DATA_ISS (byte = latched data) -> DATA_WT.
  - DATA_WT: ACK or NACK -> STOP_ISS; NACK also sets nack_flag.
  - STOP_ISS -> STOP_WT -> FINISH.
  - FINISH, exactly one cycle, three cases:
    - nack_flag=0: pulse done[g], clear gnt, go to IDLE.
    - nack_flag=1 and retry_cnt<MAX_RETRY: increment retry_cnt, clear nack_flag, go to START_ISS with gnt kept and the latched operands reused.
    - Otherwise: pulse err[g], clear gnt, go to IDLE.
  - retry_cnt clears on leaving to IDLE.
- eng_rsp_nack is ignored for START and STOP responses.
- eng_rsp_valid outside a *_WT state is ignored.
- eng_rsp_valid in the same cycle as eng_cmd_ready (zero-latency engine) is not legal; the engine guarantees at least one cycle between them.
- Requesters hold req until done or err. A req drop mid-transaction is ignored and the transaction completes. A req still high after done re-competes in IDLE, where it is lowest priority.
- done and err are never both set; at most one bit of either is set per cycle.
- A new grant is never issued in the FINISH cycle; minimum gap between transactions is 1 IDLE cycle.

Decomposition:
- Package i2c_pkg holds:
  - Command codes CMD_START, CMD_WRITE, CMD_STOP.
  - State enum.
  - Constant RW_WRITE = 1'b0.
- One sub-module, i2c_rr_arbiter: combinational round-robin pick from a req vector and pointer, returning a one-hot grant and a binary index.

Test Plan:
- Single write: req[0], addr 0x50, data 0xA5; engine ready always, rsp 3 cycles after accept, ACK.
  - Commands seen: START, WRITE 0xA0, WRITE 0xA5, STOP.
  - gnt=0001 throughout; one done[0] pulse; busy low afterwards.
- Fairness: req=1111 held continuously after reset.
  - Grant order 0,1,2,3,0,1 with a 1-cycle IDLE between each.
  - req=0101 from reset gives order 0,2,0.
- Address NACK persistent, MAX_RETRY=2.
  - Three START/WRITE 0xA0/STOP sequences with no data byte sent.
  - Then one err pulse on the granted index; no done.
- Data NACK once, then ACK on the retry.
  - Sequence START, A0, A5, STOP, START, A0, A5, STOP.
  - Ends with done pulse; err never asserted.
- Backpressure: eng_cmd_ready low for 5 cycles on the address WRITE.
  - eng_cmd_valid=1, eng_cmd=01, byte=0xA0 held stable all 5 cycles.
  - Exactly one command is accepted.
- RST pulse during DATA_WT.
  - All outputs 0 asynchronously, before the next edge.
  - After release, req[1] is served first as START with no stale retry count.
